// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes a bank from the upper address bits and sequences
// active-low chip-select / read-write / output-enable strobes with programmable wait states.
module mem_bus_ctrl #(
    parameter int                   DATA_W      = 8,
    parameter int                   ADDR_W      = 8,
    parameter int                   NUM_BANKS   = 2,
    parameter int                   WAIT_STATES = 1,
    parameter logic [NUM_BANKS-1:0] RO_MASK     = {NUM_BANKS{1'b0}}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req,
    input  logic                                 we,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [DATA_W-1:0]                    wdata,
    output logic [DATA_W-1:0]                    rdata,
    output logic                                 ready,
    output logic                                 err,
    output logic [NUM_BANKS-1:0]                 n_mem_cs,
    output logic                                 n_mem_rw,
    output logic                                 n_mem_oe,
    output logic [ADDR_W-$clog2(NUM_BANKS)-1:0]  mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]          mem_rdata
);

    localparam int         BANK_W   = $clog2(NUM_BANKS);
    localparam int         OFF_W    = ADDR_W - BANK_W;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic                we_q, we_d;
    logic                fault_q, fault_d;
    logic [OFF_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [NUM_BANKS-1:0] n_cs_q, n_cs_d;
    logic                n_rw_q, n_rw_d;
    logic                n_oe_q, n_oe_d;

    logic [BANK_W-1:0]   req_bank_s;
    logic                req_ro_s;
    logic [DATA_W-1:0]   bank_rdata_s;

    assign req_bank_s   = addr[ADDR_W-1 -: BANK_W];
    assign req_ro_s     = we & RO_MASK[req_bank_s];
    assign bank_rdata_s = mem_rdata[int'(bank_q)*DATA_W +: DATA_W];

    // Next-state logic: request capture, wait-state countdown and phase sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        we_d        = we_q;
        fault_d     = fault_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    bank_d      = req_bank_s;
                    we_d        = we;
                    fault_d     = req_ro_s;
                    cnt_d       = WAIT_CNT;
                    mem_addr_d  = addr[OFF_W-1:0];
                    mem_wdata_d = wdata;
                    state_d     = req_ro_s ? S_DONE : S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: bus outputs follow the state one cycle later so every pin is a flop.
    always_comb begin
        n_cs_d  = {NUM_BANKS{1'b1}};
        n_rw_d  = 1'b1;
        n_oe_d  = 1'b1;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_ACCESS: begin
                n_cs_d[bank_q] = 1'b0;
                n_rw_d         = ~we_q;
                n_oe_d         = we_q;
            end
            S_DONE: begin
                ready_d = 1'b1;
                err_d   = fault_q;
                if (!we_q && !fault_q) begin
                    rdata_d = bank_rdata_s;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            bank_q      <= {BANK_W{1'b0}};
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            mem_addr_q  <= {OFF_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            n_cs_q      <= {NUM_BANKS{1'b1}};
            n_rw_q      <= 1'b1;
            n_oe_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            we_q        <= we_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            n_cs_q      <= n_cs_d;
            n_rw_q      <= n_rw_d;
            n_oe_q      <= n_oe_d;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign n_mem_cs  = n_cs_q;
    assign n_mem_rw  = n_rw_q;
    assign n_mem_oe  = n_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: three instances (1, 0 and 3 wait states) share
// stimulus; completions are checked against a queue of expected results.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] mem_rdata;

    logic [7:0]  rdata_a [3];
    logic        ready_a [3];
    logic        err_a   [3];
    logic [1:0]  ncs_a   [3];
    logic        nrw_a   [3];
    logic        noe_a   [3];
    logic [6:0]  maddr_a [3];
    logic [7:0]  mwdata_a[3];

    typedef struct packed {
        logic [7:0] rd;
        logic       er;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    mem_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .NUM_BANKS(2), .WAIT_STATES(1), .RO_MASK(2'b10)) u_ws1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[0]), .ready(ready_a[0]), .err(err_a[0]), .n_mem_cs(ncs_a[0]),
        .n_mem_rw(nrw_a[0]), .n_mem_oe(noe_a[0]), .mem_addr(maddr_a[0]),
        .mem_wdata(mwdata_a[0]), .mem_rdata(mem_rdata));

    mem_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .NUM_BANKS(2), .WAIT_STATES(0), .RO_MASK(2'b10)) u_ws0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[1]), .ready(ready_a[1]), .err(err_a[1]), .n_mem_cs(ncs_a[1]),
        .n_mem_rw(nrw_a[1]), .n_mem_oe(noe_a[1]), .mem_addr(maddr_a[1]),
        .mem_wdata(mwdata_a[1]), .mem_rdata(mem_rdata));

    mem_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .NUM_BANKS(2), .WAIT_STATES(3), .RO_MASK(2'b10)) u_ws3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[2]), .ready(ready_a[2]), .err(err_a[2]), .n_mem_cs(ncs_a[2]),
        .n_mem_rw(nrw_a[2]), .n_mem_oe(noe_a[2]), .mem_addr(maddr_a[2]),
        .mem_wdata(mwdata_a[2]), .mem_rdata(mem_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on all instances and observe instance d until its ready pulse.
    task automatic run_access(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                              output int lat, output int cs_cyc, output logic bad,
                              output logic [7:0] rd, output logic er);
        logic [1:0] exp_cs;
        exp_cs        = 2'b11;
        exp_cs[a[7]]  = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = wd;
        tick();
        req = 1'b0; we = ~w; addr = 8'hFF ^ a; wdata = ~wd;
        lat = 0; cs_cyc = 0; bad = 1'b0;
        while (ready_a[d] !== 1'b1 && lat < 40) begin
            if (ncs_a[d] !== 2'b11) begin
                cs_cyc++;
                if (ncs_a[d] !== exp_cs || nrw_a[d] !== ~w || noe_a[d] !== w ||
                    maddr_a[d] !== a[6:0] || (w && mwdata_a[d] !== wd))
                    bad = 1'b1;
            end else if (nrw_a[d] !== 1'b1 || noe_a[d] !== 1'b1) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
            tick();
            lat++;
        end
        if (ncs_a[d] !== 2'b11 || noe_a[d] !== 1'b1) bad = 1'b1;
        rd = rdata_a[d];
        er = err_a[d];
    endtask

    task automatic check_done(input string name, input int lat, input int exp_lat,
                              input int cs_cyc, input int exp_cs, input logic bad,
                              input logic [7:0] rd, input logic er);
        exp_t e;
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (cs_cyc !== exp_cs || bad !== 1'b0) begin
            n_fail++; $display("FAIL %s strobes: width %0d bad %0b expected width %0d bad 0", name, cs_cyc, bad, exp_cs);
        end
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard: got completion, expected none queued", name);
        end else begin
            e = sb_q.pop_front();
            if (rd !== e.rd || er !== e.er) begin
                n_fail++; $display("FAIL %s result: got rdata %h err %b expected rdata %h err %b", name, rd, er, e.rd, e.er);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({rdata_a[d], ready_a[d], err_a[d], ncs_a[d], nrw_a[d], noe_a[d], maddr_a[d], mwdata_a[d]} !==
                {8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 7'h00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rd %h rdy %b err %b cs %b rw %b oe %b ma %h mw %h expected 00 0 0 11 1 1 00 00",
                         d, rdata_a[d], ready_a[d], err_a[d], ncs_a[d], nrw_a[d], noe_a[d], maddr_a[d], mwdata_a[d]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int lat, cs; logic bad, er; logic [7:0] rd;
        sb_q.push_back('{rd: 8'hA5, er: 1'b0});
        run_access(0, 1'b0, 8'h83, 8'h00, lat, cs, bad, rd, er);
        check_done("read", lat, 3, cs, 2, bad, rd, er);
        tick();
        n_tests++;
        if (ready_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL read_pulse: ready %b expected 0", ready_a[0]);
        end
        repeat (8) tick();
    endtask

    task automatic test_write();
        int lat, cs; logic bad, er; logic [7:0] rd;
        sb_q.push_back('{rd: 8'hA5, er: 1'b0});
        run_access(0, 1'b1, 8'h10, 8'h3C, lat, cs, bad, rd, er);
        check_done("write", lat, 3, cs, 2, bad, rd, er);
        repeat (8) tick();
    endtask

    task automatic test_read_only();
        int lat, cs; logic bad, er; logic [7:0] rd;
        sb_q.push_back('{rd: 8'hA5, er: 1'b1});
        run_access(0, 1'b1, 8'hF0, 8'h99, lat, cs, bad, rd, er);
        check_done("read_only", lat, 1, cs, 0, bad, rd, er);
        repeat (8) tick();
    endtask

    task automatic test_wait_sweep();
        int lat, cs; logic bad, er; logic [7:0] rd;
        sb_q.push_back('{rd: 8'h5A, er: 1'b0});
        run_access(1, 1'b0, 8'h05, 8'h00, lat, cs, bad, rd, er);
        check_done("ws0_read", lat, 2, cs, 1, bad, rd, er);
        repeat (8) tick();
        sb_q.push_back('{rd: 8'hA5, er: 1'b0});
        run_access(2, 1'b0, 8'h83, 8'h00, lat, cs, bad, rd, er);
        check_done("ws3_read", lat, 5, cs, 4, bad, rd, er);
        repeat (8) tick();
        sb_q.push_back('{rd: 8'hA5, er: 1'b0});
        run_access(2, 1'b1, 8'h22, 8'h81, lat, cs, bad, rd, er);
        check_done("ws3_write", lat, 5, cs, 4, bad, rd, er);
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        int lat, cs; logic bad, er, seen; logic [7:0] rd;
        mem_rdata = {8'h77, 8'h5A};
        req = 1'b1; we = 1'b0; addr = 8'h83;
        tick();
        req = 1'b0;
        tick();
        n_tests++;
        if (ncs_a[0] !== 2'b01) begin
            n_fail++; $display("FAIL mid_strobe: cs %b expected 01", ncs_a[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (ncs_a[0] !== 2'b11 || noe_a[0] !== 1'b1 || ready_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: cs %b oe %b rdy %b expected 11 1 0", ncs_a[0], noe_a[0], ready_a[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ready_a[0] === 1'b1 || ncs_a[0] !== 2'b11) seen = 1'b1;
            tick();
        end
        n_tests++;
        if (seen !== 1'b0 || rdata_a[0] !== 8'h00) begin
            n_fail++; $display("FAIL mid_no_ready: activity %b rdata %h expected 0 00", seen, rdata_a[0]);
        end
        sb_q.push_back('{rd: 8'h77, er: 1'b0});
        run_access(0, 1'b0, 8'h83, 8'h00, lat, cs, bad, rd, er);
        check_done("mid_reissue", lat, 3, cs, 2, bad, rd, er);
        repeat (8) tick();
    endtask

    task automatic test_back_to_back();
        int pulses, last;
        exp_t e;
        mem_rdata = {8'hC3, 8'h5A};
        for (int k = 0; k < 5; k++) sb_q.push_back('{rd: 8'hC3, er: 1'b0});
        req = 1'b1; we = 1'b0; addr = 8'h83;
        pulses = 0; last = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready_a[0] === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_tests++;
                    if (i - last !== 4) begin
                        n_fail++; $display("FAIL b2b_period: got %0d expected 4", i - last);
                    end
                end
                last = i;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got pulse %0d expected none", pulses);
                end else begin
                    e = sb_q.pop_front();
                    if (rdata_a[0] !== e.rd || err_a[0] !== e.er) begin
                        n_fail++; $display("FAIL b2b_result: got %h %b expected %h %b", rdata_a[0], err_a[0], e.rd, e.er);
                    end
                end
            end else if (pulses > 0) begin
                n_tests++;
                if (rdata_a[0] !== 8'hC3) begin
                    n_fail++; $display("FAIL b2b_stable: rdata %h expected c3", rdata_a[0]);
                end
            end else begin
                last = last;
            end
        end
        req = 1'b0;
        n_tests++;
        if (pulses !== 5 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses expected 5", pulses);
            sb_q.delete();
        end
        repeat (8) tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        mem_rdata = {8'hA5, 8'h5A};
        test_reset();
        test_read();
        test_write();
        test_read_only();
        test_wait_sweep();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
